// File: rtl/vga_pkg.sv
// Shared 640x480@60Hz raster constants and the coordinate type used by the
// timing generator, colour mapper and motion logic.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int CLK_DIV   = 2;
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-enable divider: pix_en_o pulses once every DIV clocks, and vga_clk_o
// is the registered high half of the divider phase.
module vga_pix_div
    import vga_pkg::*;
#(
    parameter int DIV = CLK_DIV
) (
    input  logic Clk,
    input  logic Reset_n,
    output logic pix_en_o,
    output logic vga_clk_o
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          vga_clk_q, vga_clk_d;

    always_comb begin
        pix_en_o  = (div_q == DW'(DIV - 1));
        div_d     = pix_en_o ? '0 : div_q + 1'b1;
        vga_clk_d = (div_d >= DW'(DIV / 2));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q     <= '0;
            vga_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            vga_clk_q <= vga_clk_d;
        end
    end

    assign vga_clk_o = vga_clk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters, sync decode and a one-pixel output stage
// that aligns colour with HS/VS/BLANK_N, plus the frame tick at vertical blank.
module vga_timing_gen
    import vga_pkg::coord_t;
#(
    parameter int CLK_DIV   = vga_pkg::CLK_DIV,
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Red,
    input  logic [7:0] Green,
    input  logic [7:0] Blue,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_start
);

    localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic       pix_en;
    logic       line_wrap;
    logic       visible;
    coord_t     hc_q, hc_d, vc_q, vc_d;
    logic       hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d, frame_q, frame_d;
    logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

    vga_pix_div #(.DIV(CLK_DIV)) u_pix_div (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .pix_en_o  (pix_en),
        .vga_clk_o (VGA_CLK)
    );

    // >= rather than == so a corrupted counter still returns to 0.
    assign line_wrap = (hc_q >= H_LAST);
    assign visible   = (hc_q < H_VIS) && (vc_q < V_VIS);

    always_comb begin
        hc_d      = hc_q;
        vc_d      = vc_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        frame_d   = 1'b0;
        if (pix_en) begin
            if (line_wrap) begin
                hc_d = '0;
                vc_d = (vc_q >= V_LAST) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
            hs_d      = ~((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
            vs_d      = ~((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));
            blank_n_d = visible;
            r_d       = visible ? Red   : 8'h00;
            g_d       = visible ? Green : 8'h00;
            b_d       = visible ? Blue  : 8'h00;
            frame_d   = line_wrap && (vc_d == V_VIS);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hc_q      <= '0;
            vc_q      <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= 8'h00;
            g_q       <= 8'h00;
            b_q       <= 8'h00;
            frame_q   <= 1'b0;
        end else begin
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            frame_q   <= frame_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level timing and a
// shrunken-geometry instance so whole frames fit in a short run.
module tb_vga_timing_gen;

    localparam int D = 2;
    localparam int F_HV = 640, F_HF = 16, F_HS = 96, F_HB = 48;
    localparam int F_VV = 480, F_VF = 10, F_VS = 2,  F_VB = 33;
    localparam int S_HV = 20,  S_HF = 4,  S_HS = 6,  S_HB = 5;
    localparam int S_VV = 12,  S_VF = 2,  S_VS = 2,  S_VB = 3;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] Red = 8'h00, Green = 8'h00, Blue = 8'h00;

    logic [9:0] f_dx, f_dy, s_dx, s_dy;
    logic       f_clk, f_hs, f_vs, f_bn, f_fs;
    logic       s_clk, s_hs, s_vs, s_bn, s_fs;
    logic [7:0] f_r, f_g, f_b, s_r, s_g, s_b;

    int unsigned k = 0;
    logic [23:0] cap = 24'h0;
    int npass = 0, nfail = 0, ntotal = 0;

    always #10 Clk = ~Clk;

    vga_timing_gen dut (
        .Clk(Clk), .Reset_n(Reset_n), .Red(Red), .Green(Green), .Blue(Blue),
        .DrawX(f_dx), .DrawY(f_dy), .VGA_CLK(f_clk), .VGA_HS(f_hs), .VGA_VS(f_vs),
        .VGA_BLANK_N(f_bn), .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b), .frame_start(f_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(D), .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) dut_s (
        .Clk(Clk), .Reset_n(Reset_n), .Red(Red), .Green(Green), .Blue(Blue),
        .DrawX(s_dx), .DrawY(s_dy), .VGA_CLK(s_clk), .VGA_HS(s_hs), .VGA_VS(s_vs),
        .VGA_BLANK_N(s_bn), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .frame_start(s_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d k=%0d", tag, obs, expv, k);
        end
    endtask

    // Expected outputs derived from the count of clocks since reset release:
    // n pixel enables have happened; registered outputs describe pixel n-1.
    task automatic check_inst(input string nm,
                              input int hv, input int hf, input int hs, input int hb,
                              input int vv, input int vf, input int vs, input int vb,
                              input logic [9:0] dx, input logic [9:0] dy,
                              input logic oclk, input logic ohs, input logic ovs,
                              input logic obn, input logic [7:0] o_r,
                              input logic [7:0] o_g, input logic [7:0] o_b,
                              input logic ofs);
        int ht, vt, n, p, ph, pv;
        logic ehs, evs, ebn, efs;
        logic [23:0] ergb;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        n  = int'(k / D);
        if (n == 0) begin
            ehs = 1'b1; evs = 1'b1; ebn = 1'b0; ergb = 24'h0;
        end else begin
            p   = n - 1;
            ph  = p % ht;
            pv  = (p / ht) % vt;
            ehs = !(ph >= hv + hf && ph < hv + hf + hs);
            evs = !(pv >= vv + vf && pv < vv + vf + vs);
            ebn = (ph < hv) && (pv < vv);
            ergb = ebn ? cap : 24'h0;
        end
        efs = (k > 0) && (k % D == 0) && (n % (ht * vt) == vv * ht);
        chk({nm, ".DrawX"},       32'(dx),    32'(n % ht));
        chk({nm, ".DrawY"},       32'(dy),    32'((n / ht) % vt));
        chk({nm, ".VGA_CLK"},     32'(oclk),  32'((k % D) >= D / 2));
        chk({nm, ".VGA_HS"},      32'(ohs),   32'(ehs));
        chk({nm, ".VGA_VS"},      32'(ovs),   32'(evs));
        chk({nm, ".VGA_BLANK_N"}, 32'(obn),   32'(ebn));
        chk({nm, ".VGA_R"},       32'(o_r),   32'(ergb[23:16]));
        chk({nm, ".VGA_G"},       32'(o_g),   32'(ergb[15:8]));
        chk({nm, ".VGA_B"},       32'(o_b),   32'(ergb[7:0]));
        chk({nm, ".frame_start"}, 32'(ofs),   32'(efs));
    endtask

    task automatic check_all();
        check_inst("full", F_HV, F_HF, F_HS, F_HB, F_VV, F_VF, F_VS, F_VB,
                   f_dx, f_dy, f_clk, f_hs, f_vs, f_bn, f_r, f_g, f_b, f_fs);
        check_inst("small", S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB,
                   s_dx, s_dy, s_clk, s_hs, s_vs, s_bn, s_r, s_g, s_b, s_fs);
    endtask

    task automatic new_colour();
        if ($urandom_range(0, 1) == 1) begin
            Red = 8'hFF; Green = 8'h00; Blue = 8'hFF;
        end else begin
            Red = 8'($urandom); Green = 8'($urandom); Blue = 8'($urandom);
        end
    endtask

    task automatic step();
        if (Reset_n && ((k + 1) % D == 0)) cap = {Red, Green, Blue};
        @(posedge Clk);
        #1;
        if (Reset_n) k++;
        check_all();
        new_colour();
    endtask

    initial begin
        new_colour();
        repeat (3) step();

        Reset_n = 1'b1;
        repeat (5000 + $urandom_range(0, 60)) step();

        // Asynchronous reset mid-line: outputs must clear without a clock edge.
        Reset_n = 1'b0;
        #1;
        k = 0;
        check_all();
        repeat (3) step();

        Reset_n = 1'b1;
        repeat (3000) step();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
